pipe_stage_buf: RTL and testbench



---
 rtl/pipe_stage_buf.sv | 113 +++++++++++
 tb/tb_pipe_stage_buf.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register with valid/ready handshake, flush-to-bubble,
// optional 2-entry skid buffer (registered in_ready) and a saturating stall counter.
module pipe_stage_buf #(
  parameter int unsigned       DATA_W     = 96,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
  parameter bit                SKID_EN    = 1'b1,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  main_q, main_d;
  logic [DATA_W-1:0]  skid_q, skid_d;
  logic               in_ready_q, in_ready_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               in_xfer;
  logic               out_xfer;

  // main_q always holds the older beat; skid_q only ever holds the younger one.
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = out_valid ? main_q : BUBBLE_VAL;
  assign occupancy = state_q;
  assign stall_cnt = stall_cnt_q;

  // With the skid buffer, in_ready is a flop and never sees out_ready.
  assign in_ready = SKID_EN ? in_ready_q : (!out_valid || out_ready);
  assign in_xfer  = in_valid && in_ready && !flush;
  assign out_xfer = out_valid && out_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer && SKID_EN) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_FULL);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr) begin
      stall_cnt_d = '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // NOTE: payload registers are not reset; out_data is muxed to BUBBLE_VAL while empty.
  always_ff @(posedge clock) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf: a skid instance (CNT_W=4)
// and a single-register instance (SKID_EN=0), both with a NOP bubble value.
module tb_pipe_stage_buf;

  localparam int unsigned       DW  = 32;
  localparam logic [DW-1:0]     NOP = 32'h0000_0013;

  logic          clock;
  logic          reset;

  logic          flush, in_valid, in_ready, out_valid, out_ready, stall_clr;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;
  logic [3:0]    stall_cnt;

  logic          flush_s0, in_valid_s0, in_ready_s0, out_valid_s0, out_ready_s0, stall_clr_s0;
  logic [DW-1:0] in_data_s0, out_data_s0;
  logic [1:0]    occupancy_s0;
  logic [15:0]   stall_cnt_s0;

  int tests_run;
  int tests_failed;

  pipe_stage_buf #(.DATA_W(DW), .BUBBLE_VAL(NOP), .SKID_EN(1'b1), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  pipe_stage_buf #(.DATA_W(DW), .BUBBLE_VAL(NOP), .SKID_EN(1'b0), .CNT_W(16)) dut_s0 (
    .clock(clock), .reset(reset), .flush(flush_s0),
    .in_valid(in_valid_s0), .in_ready(in_ready_s0), .in_data(in_data_s0),
    .out_valid(out_valid_s0), .out_ready(out_ready_s0), .out_data(out_data_s0),
    .occupancy(occupancy_s0), .stall_cnt(stall_cnt_s0), .stall_clr(stall_clr_s0)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b1;
    flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stall_clr = 1'b0;
    flush_s0 = 1'b0; in_valid_s0 = 1'b0; in_data_s0 = '0; out_ready_s0 = 1'b0; stall_clr_s0 = 1'b0;

    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data, NOP);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_in_ready",  32'(in_ready), 32'd1);
    check("rst_s0_out_data", out_data_s0, NOP);
    #8 reset = 1'b0;

    // Streaming: 8 back-to-back beats with out_ready held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h1;
    #1 check("stream_in_ready_pre", 32'(in_ready), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("stream_valid_%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("stream_data_%0d", i), out_data, 32'(i));
      check($sformatf("stream_in_ready_%0d", i), 32'(in_ready), 32'd1);
      if (i < 8) in_data = 32'(i + 1);
      else       in_valid = 1'b0;
    end
    tick();
    check("stream_drain_valid", 32'(out_valid), 32'd0);
    check("stream_drain_data",  out_data, NOP);
    check("stream_stall_cnt",   32'(stall_cnt), 32'd0);

    // Back-pressure into the skid buffer.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    tick();
    check("bp_occ_1", 32'(occupancy), 32'd1);
    check("bp_data_a", out_data, 32'hA);
    in_data = 32'hB;
    tick();
    check("bp_occ_2", 32'(occupancy), 32'd2);
    check("bp_in_ready_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    in_data  = 32'hDEAD;
    tick();
    tick();
    check("bp_stall_3", 32'(stall_cnt), 32'd3);
    check("bp_hold_a", out_data, 32'hA);
    out_ready = 1'b1;
    #1 check("bp_in_ready_no_comb", 32'(in_ready), 32'd0);
    check("bp_first_a", out_data, 32'hA);
    tick();
    check("bp_second_b", out_data, 32'hB);
    check("bp_in_ready_back", 32'(in_ready), 32'd1);
    check("bp_stall_hold", 32'(stall_cnt), 32'd3);
    tick();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Flush while FULL, with a beat offered in the same cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h1D;
    tick();
    in_data = 32'h1E;
    tick();
    check("fl_occ_full", 32'(occupancy), 32'd2);
    in_data = 32'hC;
    flush   = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_out_data", out_data, NOP);
    check("fl_occupancy", 32'(occupancy), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    tick();
    check("fl_no_c", 32'(out_valid), 32'd0);

    // Flush from ONE with in_ready=1: the offered beat is still dropped.
    in_valid = 1'b1;
    in_data  = 32'h2A;
    tick();
    in_data = 32'hC;
    flush   = 1'b1;
    #1 check("fl1_in_ready", 32'(in_ready), 32'd1);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl1_dropped", 32'(out_valid), 32'd0);
    check("fl1_bubble", out_data, NOP);

    // Saturation of the 4-bit stall counter, then clear during a stall.
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    check("sat_cleared", 32'(stall_cnt), 32'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("sat_15", 32'(stall_cnt), 32'd15);
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    check("sat_clr_wins", 32'(stall_cnt), 32'd0);
    tick();
    check("sat_restart", 32'(stall_cnt), 32'd1);

    // Asynchronous reset between edges while FULL.
    in_valid = 1'b1;
    in_data  = 32'h56;
    tick();
    in_valid = 1'b0;
    check("ar_full", 32'(occupancy), 32'd2);
    #2 reset = 1'b1;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_out_data", out_data, NOP);
    check("ar_occupancy", 32'(occupancy), 32'd0);
    check("ar_in_ready", 32'(in_ready), 32'd1);
    check("ar_stall_cnt", 32'(stall_cnt), 32'd0);
    #2 reset = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h77;
    tick();
    in_valid = 1'b0;
    check("ar_latency_valid", 32'(out_valid), 32'd1);
    check("ar_latency_data", out_data, 32'h77);

    // Single-register variant: combinational in_ready and no-gap handover.
    out_ready_s0 = 1'b0;
    in_valid_s0  = 1'b1;
    in_data_s0   = 32'h5;
    tick();
    check("s0_hold_5", out_data_s0, 32'h5);
    in_data_s0 = 32'h6;
    #1 check("s0_in_ready_lo", 32'(in_ready_s0), 32'd0);
    tick();
    check("s0_still_5", out_data_s0, 32'h5);
    check("s0_occ_max1", 32'(occupancy_s0), 32'd1);
    out_ready_s0 = 1'b1;
    #1 check("s0_in_ready_comb", 32'(in_ready_s0), 32'd1);
    tick();
    in_valid_s0 = 1'b0;
    check("s0_valid_6", 32'(out_valid_s0), 32'd1);
    check("s0_data_6", out_data_s0, 32'h6);
    tick();
    check("s0_empty_valid", 32'(out_valid_s0), 32'd0);
    check("s0_empty_bubble", out_data_s0, NOP);
    check("s0_stall_cnt", 32'(stall_cnt_s0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
